// File: rtl/arc4_enc_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : arc4_enc_if
//  Purpose  : Bundles the start handshake, the key and the three RAM ports
//             (S state, plaintext, ciphertext) used by arc4_enc.
//  Modports : master - the encryptor (drives handshake status and all RAM
//                      addresses / write data / write enables)
//             slave  - the environment (drives en, key and RAM read data)
//  Revision : 1.0 - initial release
// ============================================================================
interface arc4_enc_if;
   logic        en;       // start request
   logic        rdy;      // idle, able to accept en
   logic [23:0] key;      // key[23:16]=byte0, key[15:8]=byte1, key[7:0]=byte2
   logic [7:0]  s_addr;   // S RAM address
   logic [7:0]  s_din;    // S RAM write data
   logic [7:0]  s_dout;   // S RAM read data (one cycle after address)
   logic        s_wren;   // S RAM write enable
   logic [7:0]  pt_addr;  // plaintext RAM read address
   logic [7:0]  pt_dout;  // plaintext RAM read data (one cycle after address)
   logic [7:0]  ct_addr;  // ciphertext RAM write address
   logic [7:0]  ct_din;   // ciphertext RAM write data
   logic        ct_wren;  // ciphertext RAM write enable

   modport master (
      input  en, key, s_dout, pt_dout,
      output rdy, s_addr, s_din, s_wren, pt_addr, ct_addr, ct_din, ct_wren
   );

   modport slave (
      output en, key, s_dout, pt_dout,
      input  rdy, s_addr, s_din, s_wren, pt_addr, ct_addr, ct_din, ct_wren
   );
endinterface
`default_nettype wire

// File: rtl/arc4_enc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : arc4_enc
//  Purpose  : ARC4 encryptor for length-prefixed messages. Reads PT[0]=len
//             and PT[1..len], writes CT[0]=len and CT[k]=PT[k]^pad_k.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - arc4_enc_if.master (en/rdy handshake, key, S/PT/CT RAMs)
//  Options  : ARC4_ENC_KSA_EN - when defined, S is initialised to identity
//             and key-scheduled on every start; when undefined, S is assumed
//             already scheduled upstream and key is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module arc4_enc (
   input  wire logic     clk,
   input  wire logic     rst_n,
   arc4_enc_if.master    bus
);

   typedef enum logic [4:0] {
      S_IDLE     = 5'd0,
      S_INIT     = 5'd1,
      S_KSA      = 5'd2,
      S_LEN_ADDR = 5'd3,
      S_LEN_WAIT = 5'd4,
      S_LEN_WR   = 5'd5,
      S_I_UPD    = 5'd6,
      S_SI_ADDR  = 5'd7,
      S_SI_WAIT  = 5'd8,
      S_SI_CP    = 5'd9,
      S_J_UPD    = 5'd10,
      S_SJ_ADDR  = 5'd11,
      S_SJ_WAIT  = 5'd12,
      S_SJ_CP    = 5'd13,
      S_ST_SI    = 5'd14,
      S_ST_SJ    = 5'd15,
      S_PAD_ADDR = 5'd16,
      S_PAD_WAIT = 5'd17,
      S_PAD_CP   = 5'd18,
      S_PT_ADDR  = 5'd19,
      S_PT_WAIT  = 5'd20,
      S_CT_WR    = 5'd21,
      S_DONE     = 5'd22
   } state_t;

   state_t     r_state;
   state_t     w_next;

   logic [7:0] r_i;
   logic [7:0] r_j;
   logic [7:0] r_si;
   logic [7:0] r_sj;
   logic [7:0] r_pad;
   logic [7:0] r_len;
   logic [8:0] r_k;        // bytes already written; 9 bits so len=255 ends
   logic [8:0] w_k_next;

   logic [7:0] r_s_addr;
   logic [7:0] r_s_din;
   logic       r_s_wren;
   logic [7:0] r_pt_addr;
   logic [7:0] r_ct_addr;
   logic [7:0] r_ct_din;
   logic       r_ct_wren;

`ifdef ARC4_ENC_KSA_EN
   localparam logic [2:0] c_PH_LAST = 3'd6;
   logic [23:0] r_key;
   logic [1:0]  r_kidx;    // i mod 3, selects the key byte
   logic [2:0]  r_ph;      // sub-step within one KSA iteration
   logic [7:0]  w_kbyte;
   logic [7:0]  w_ksa_j;

   always_comb begin
      w_kbyte = r_key[7:0];
      case (r_kidx)
         2'd0:    w_kbyte = r_key[23:16];
         2'd1:    w_kbyte = r_key[15:8];
         default: w_kbyte = r_key[7:0];
      endcase
   end

   assign w_ksa_j = r_j + bus.s_dout + w_kbyte;
`endif

   assign w_k_next = r_k + 9'd1;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.en) begin
`ifdef ARC4_ENC_KSA_EN
               w_next = S_INIT;
`else
               w_next = S_LEN_ADDR;
`endif
            end
         end
`ifdef ARC4_ENC_KSA_EN
         S_INIT:     if (r_i == 8'hFF) w_next = S_KSA;
         S_KSA:      if (r_ph == c_PH_LAST && r_i == 8'hFF) w_next = S_LEN_ADDR;
`endif
         S_LEN_ADDR: w_next = S_LEN_WAIT;
         S_LEN_WAIT: w_next = S_LEN_WR;
         S_LEN_WR:   w_next = (r_len == 8'd0) ? S_DONE : S_I_UPD;
         S_I_UPD:    w_next = S_SI_ADDR;
         S_SI_ADDR:  w_next = S_SI_WAIT;
         S_SI_WAIT:  w_next = S_SI_CP;
         S_SI_CP:    w_next = S_J_UPD;
         S_J_UPD:    w_next = S_SJ_ADDR;
         S_SJ_ADDR:  w_next = S_SJ_WAIT;
         S_SJ_WAIT:  w_next = S_SJ_CP;
         S_SJ_CP:    w_next = S_ST_SI;
         S_ST_SI:    w_next = S_ST_SJ;
         S_ST_SJ:    w_next = S_PAD_ADDR;
         S_PAD_ADDR: w_next = S_PAD_WAIT;
         S_PAD_WAIT: w_next = S_PAD_CP;
         S_PAD_CP:   w_next = S_PT_ADDR;
         S_PT_ADDR:  w_next = S_PT_WAIT;
         S_PT_WAIT:  w_next = S_CT_WR;
         S_CT_WR:    w_next = (w_k_next == {1'b0, r_len}) ? S_DONE : S_I_UPD;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // Output registers are loaded one state ahead so that every RAM address
   // or write strobe is already stable during the state that owns it. Reads
   // therefore land in the *_WAIT state and are captured in *_CP; writes
   // are visible on the bus during the state following the one that set
   // them up, which keeps both write enables low in IDLE and DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_i       <= 8'd0;
         r_j       <= 8'd0;
         r_si      <= 8'd0;
         r_sj      <= 8'd0;
         r_pad     <= 8'd0;
         r_len     <= 8'd0;
         r_k       <= 9'd0;
         r_s_addr  <= 8'd0;
         r_s_din   <= 8'd0;
         r_s_wren  <= 1'b0;
         r_pt_addr <= 8'd0;
         r_ct_addr <= 8'd0;
         r_ct_din  <= 8'd0;
         r_ct_wren <= 1'b0;
`ifdef ARC4_ENC_KSA_EN
         r_key     <= 24'd0;
         r_kidx    <= 2'd0;
         r_ph      <= 3'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.en) begin
                  r_i       <= 8'd0;
                  r_j       <= 8'd0;
                  r_k       <= 9'd0;
                  r_pt_addr <= 8'd0;
`ifdef ARC4_ENC_KSA_EN
                  r_key     <= bus.key;
                  r_kidx    <= 2'd0;
                  r_ph      <= 3'd0;
                  r_s_addr  <= 8'd0;   // first identity write S[0]=0
                  r_s_din   <= 8'd0;
                  r_s_wren  <= 1'b1;
`endif
               end
            end
`ifdef ARC4_ENC_KSA_EN
            // One identity write per cycle, r_i tracks the address on the bus.
            S_INIT: begin
               if (r_i == 8'hFF) begin
                  r_s_wren <= 1'b0;
                  r_i      <= 8'd0;
               end else begin
                  r_i      <= r_i + 8'd1;
                  r_s_addr <= r_i + 8'd1;
                  r_s_din  <= r_i + 8'd1;
               end
            end
            // ph0 addr S[i], ph2 capture si and address S[j'], ph4 capture
            // sj and write S[i]=sj, ph5 write S[j]=si, ph6 advance i.
            S_KSA: begin
               r_ph <= (r_ph == c_PH_LAST) ? 3'd0 : r_ph + 3'd1;
               case (r_ph)
                  3'd0: r_s_addr <= r_i;
                  3'd2: begin
                     r_si     <= bus.s_dout;
                     r_j      <= w_ksa_j;
                     r_s_addr <= w_ksa_j;
                  end
                  3'd4: begin
                     r_sj     <= bus.s_dout;
                     r_s_addr <= r_i;
                     r_s_din  <= bus.s_dout;
                     r_s_wren <= 1'b1;
                  end
                  3'd5: begin
                     r_s_addr <= r_j;
                     r_s_din  <= r_si;
                     r_s_wren <= 1'b1;
                  end
                  c_PH_LAST: begin
                     r_s_wren <= 1'b0;
                     r_kidx   <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
                     if (r_i == 8'hFF) begin
                        r_i       <= 8'd0;
                        r_j       <= 8'd0;   // PRGA starts from j=0
                        r_pt_addr <= 8'd0;
                     end else begin
                        r_i <= r_i + 8'd1;
                     end
                  end
                  default: ;
               endcase
            end
`endif
            S_LEN_WAIT: begin
               r_len     <= bus.pt_dout;
               r_ct_addr <= 8'd0;
               r_ct_din  <= bus.pt_dout;
               r_ct_wren <= 1'b1;
            end
            S_LEN_WR: r_ct_wren <= 1'b0;
            S_I_UPD: begin
               r_i      <= r_i + 8'd1;
               r_s_addr <= r_i + 8'd1;
            end
            S_SI_CP: r_si <= bus.s_dout;
            S_J_UPD: begin
               r_j      <= r_j + r_si;
               r_s_addr <= r_j + r_si;
            end
            S_SJ_CP: begin
               r_sj     <= bus.s_dout;
               r_s_addr <= r_i;
               r_s_din  <= bus.s_dout;
               r_s_wren <= 1'b1;
            end
            S_ST_SI: begin
               r_s_addr <= r_j;
               r_s_din  <= r_si;
               r_s_wren <= 1'b1;
            end
            // si+sj is invariant under the swap, so the pre-swap copies
            // address the pad byte; the read lands after both writes.
            S_ST_SJ: begin
               r_s_wren <= 1'b0;
               r_s_addr <= r_si + r_sj;
            end
            S_PAD_CP: begin
               r_pad     <= bus.s_dout;
               r_pt_addr <= w_k_next[7:0];
            end
            S_PT_WAIT: begin
               r_ct_addr <= w_k_next[7:0];
               r_ct_din  <= bus.pt_dout ^ r_pad;
               r_ct_wren <= 1'b1;
            end
            S_CT_WR: begin
               r_ct_wren <= 1'b0;
               r_k       <= w_k_next;
            end
            default: ;
         endcase
      end
   end

   assign bus.rdy     = (r_state == S_IDLE);
   assign bus.s_addr  = r_s_addr;
   assign bus.s_din   = r_s_din;
   assign bus.s_wren  = r_s_wren;
   assign bus.pt_addr = r_pt_addr;
   assign bus.ct_addr = r_ct_addr;
   assign bus.ct_din  = r_ct_din;
   assign bus.ct_wren = r_ct_wren;

endmodule
`default_nettype wire

// File: tb/tb_arc4_enc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_arc4_enc
//  Purpose  : Self-checking bench for arc4_enc. Models the S/PT/CT RAMs and
//             compares every run against a plain software RC4 reference.
//             Honours ARC4_ENC_KSA_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arc4_enc;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   arc4_enc_if bus ();

   arc4_enc dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef ARC4_ENC_KSA_EN
   localparam int c_PRE = 256 + 256 * 7;
`else
   localparam int c_PRE = 0;
`endif
   localparam int  c_BUDGET = 8000;
   localparam logic [7:0] c_CT_FILL = 8'hC3;

   logic [7:0]  s_mem  [256];
   logic [7:0]  s_init [256];
   logic [7:0]  pt_mem [256];
   logic [7:0]  ct_mem [256];
   logic        load_req = 1'b0;
   int          ct_wr_cnt   = 0;
   int          idle_wr_cnt = 0;
   logic [23:0] cur_key = 24'd0;

   int n_cmp  = 0;
   int n_fail = 0;

   int ref_s  [256];
   int exp_ct [256];
   int exp_len;
   int c0_ct, c0_idle;

   // RAM models: synchronous read, one cycle latency, read-before-write.
   always @(posedge clk) begin
      if (load_req) begin
         for (int x = 0; x < 256; x++) begin
            s_mem[x]  <= s_init[x];
            ct_mem[x] <= c_CT_FILL;
         end
      end else begin
         if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_din;
         if (bus.ct_wren) begin
            ct_mem[bus.ct_addr] <= bus.ct_din;
            ct_wr_cnt <= ct_wr_cnt + 1;
         end
         if ((bus.s_wren || bus.ct_wren) && bus.rdy) idle_wr_cnt <= idle_wr_cnt + 1;
      end
      bus.s_dout  <= s_mem[bus.s_addr];
      bus.pt_dout <= pt_mem[bus.pt_addr];
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Software RC4 over the staged S image and PT buffer.
   task automatic run_model();
      int i, j, t, len;
      for (int x = 0; x < 256; x++) ref_s[x] = int'(s_init[x]);
`ifdef ARC4_ENC_KSA_EN
      for (int x = 0; x < 256; x++) ref_s[x] = x;
      j = 0;
      for (int x = 0; x < 256; x++) begin
         j = (j + ref_s[x] + int'((cur_key >> (8 * (2 - x % 3))) & 24'hFF)) % 256;
         t = ref_s[x]; ref_s[x] = ref_s[j]; ref_s[j] = t;
      end
`endif
      len       = int'(pt_mem[0]);
      exp_len   = len;
      exp_ct[0] = len;
      i = 0;
      j = 0;
      for (int k = 1; k <= len; k++) begin
         i = (i + 1) % 256;
         j = (j + ref_s[i]) % 256;
         t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
         exp_ct[k] = int'(pt_mem[k]) ^ ref_s[(ref_s[i] + ref_s[j]) % 256];
      end
   endtask

   task automatic identity_s();
      for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
   endtask

   task automatic random_s();
      int r;
      logic [7:0] t;
      identity_s();
      for (int x = 255; x > 0; x--) begin
         r = $urandom_range(0, x);
         t = s_init[x]; s_init[x] = s_init[r]; s_init[r] = t;
      end
   endtask

   task automatic load();
      load_req = 1'b1;
      @(posedge clk); #1;
      load_req = 1'b0;
      bus.key  = cur_key;
      run_model();
      c0_ct   = ct_wr_cnt;
      c0_idle = idle_wr_cnt;
   endtask

   task automatic do_run(input string tag, input bit jitter, output int cycles);
      int c;
      bit done;
      bus.en = 1'b1;
      @(posedge clk); #1;
      bus.en = 1'b0;
      chk({tag, "_rdy_drop"}, 32'(bus.rdy), 32'd0);
      done = 1'b0;
      c = 0;
      while (!done && c < c_BUDGET) begin
         if (jitter) bus.en = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         c++;
         if (bus.rdy) begin
            done   = 1'b1;
            bus.en = 1'b0;
         end
      end
      bus.en = 1'b0;
      chk({tag, "_terminated"}, 32'(done), 32'd1);
      cycles = c;
   endtask

   task automatic check_result(input string tag);
      int bad_s;
      for (int k = 0; k <= exp_len; k++)
         chk($sformatf("%s_ct%0d", tag, k), 32'(ct_mem[k]), 32'(exp_ct[k]));
      chk({tag, "_ct_writes"}, 32'(ct_wr_cnt - c0_ct), 32'(exp_len + 1));
      chk({tag, "_idle_writes"}, 32'(idle_wr_cnt - c0_idle), 32'd0);
      bad_s = 0;
      for (int x = 0; x < 256; x++) if (int'(s_mem[x]) != ref_s[x]) bad_s++;
      chk({tag, "_s_bad_entries"}, 32'(bad_s), 32'd0);
   endtask

   task automatic full_case(input string tag, input bit jitter);
      int cyc;
      load();
      do_run(tag, jitter, cyc);
      check_result(tag);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_no_rerun"}, 32'(ct_wr_cnt - c0_ct), 32'(exp_len + 1));
      chk({tag, "_rdy_stays"}, 32'(bus.rdy), 32'd1);
   endtask

   initial begin
      int cyc, len;
      bus.en  = 1'b0;
      bus.key = 24'd0;
      for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
      identity_s();

      // Reset state
      #12;
      chk("rst_rdy",     32'(bus.rdy),     32'd1);
      chk("rst_s_wren",  32'(bus.s_wren),  32'd0);
      chk("rst_ct_wren", 32'(bus.ct_wren), 32'd0);
      chk("rst_s_addr",  32'(bus.s_addr),  32'd0);
      chk("rst_s_din",   32'(bus.s_din),   32'd0);
      chk("rst_pt_addr", 32'(bus.pt_addr), 32'd0);
      chk("rst_ct_addr", 32'(bus.ct_addr), 32'd0);
      chk("rst_ct_din",  32'(bus.ct_din),  32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Empty message
      identity_s();
      pt_mem[0] = 8'h00;
      load();
      do_run("len0", 1'b0, cyc);
      check_result("len0");
      chk("len0_rdy_within", 32'(cyc <= 5 + c_PRE), 32'd1);

      // Two-byte message against known answer
      identity_s();
      pt_mem[0] = 8'h02; pt_mem[1] = 8'hAA; pt_mem[2] = 8'h55;
      full_case("kat2", 1'b0);
`ifndef ARC4_ENC_KSA_EN
      chk("kat2_ct1_const", 32'(ct_mem[1]), 32'hA8);
      chk("kat2_ct2_const", 32'(ct_mem[2]), 32'h50);
      chk("kat2_s2_const",  32'(s_mem[2]),  32'h03);
      chk("kat2_s3_const",  32'(s_mem[3]),  32'h02);
`else
      // Zero key, three bytes, then decrypt by re-encrypting
      cur_key = 24'h000000;
      pt_mem[0] = 8'h03; pt_mem[1] = 8'h11; pt_mem[2] = 8'h22; pt_mem[3] = 8'h33;
      full_case("kat3", 1'b0);
      for (int x = 0; x < 4; x++) pt_mem[x] = ct_mem[x];
      full_case("kat3_rt", 1'b0);
      chk("kat3_rt_b1", 32'(ct_mem[1]), 32'h11);
      chk("kat3_rt_b2", 32'(ct_mem[2]), 32'h22);
      chk("kat3_rt_b3", 32'(ct_mem[3]), 32'h33);
`endif

      // Randomised messages, S images and keys; last two with en chatter
      for (int n = 0; n < 6; n++) begin
         random_s();
         cur_key = 24'($urandom);
         len = (n == 2) ? 0 : $urandom_range(1, 40);
         pt_mem[0] = 8'(len);
         for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
         full_case($sformatf("rnd%0d", n), n >= 4);
      end

      // Reset in the middle of the keystream loop, then a clean rerun
      identity_s();
      cur_key = 24'h5A3C11;
      pt_mem[0] = 8'd20;
      for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
      load();
      bus.en = 1'b1;
      @(posedge clk); #1;
      bus.en = 1'b0;
      repeat (c_PRE + 60) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_rdy",     32'(bus.rdy),     32'd1);
      chk("abort_s_wren",  32'(bus.s_wren),  32'd0);
      chk("abort_ct_wren", 32'(bus.ct_wren), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      full_case("after_abort", 1'b0);

      // Maximum length
      identity_s();
      pt_mem[0] = 8'hFF;
      for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
      full_case("len255", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arc4_enc.md
ARC4_ENC -- requirements
Module: arc4_enc

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  start request; sampled only while rdy=1.
REQ-004 rdy  output  1  high only when idle and able to accept en.
REQ-005 key  input  24  ARC4 key; key[23:16]=byte0, key[15:8]=byte1, key[7:0]=byte2; latched on accepted start.
REQ-006 s_addr/s_din  output  8/8  state RAM (S) address and write data.
REQ-007 s_dout  input  8  S read data, valid one cycle after s_addr is registered.
REQ-008 s_wren  output  1  S write enable.
REQ-009 pt_addr  output  8  plaintext RAM read address; pt_dout (input 8) is valid one cycle later.
REQ-010 ct_addr/ct_din  output  8/8  ciphertext RAM write address and data.
REQ-011 ct_wren  output  1  ciphertext write enable.

Function
REQ-012 The block SHALL be the writer of length-prefixed ciphertext: it reads PT[0]=len and PT[1..len], and writes CT[0]=len and CT[k]=PT[k] XOR pad_k for k=1..len.
REQ-013 A start SHALL occur on any rising edge where rdy=1 and en=1; rdy SHALL drop the following cycle and stay low until the run is complete.
REQ-014 en SHALL be ignored while rdy=0; no queuing of requests.
REQ-015 State sequence: IDLE -> [INIT -> KSA, if compiled in] -> LEN_ADDR -> LEN_WAIT -> LEN_WR -> {I_UPD -> SI_ADDR -> SI_WAIT -> SI_CP -> J_UPD -> SJ_ADDR -> SJ_WAIT -> SJ_CP -> ST_SI -> ST_SJ -> PAD_ADDR -> PAD_WAIT -> PAD_CP -> PT_ADDR -> PT_WAIT -> CT_WR} x len -> DONE -> IDLE.
REQ-016 PRGA: i=(i+1) mod 256, j=(j+S[i]) mod 256, swap S[i]/S[j], pad=S[(S[i]+S[j]) mod 256] using pre-swap values si/sj; i, j, k start at 0 for every run.
REQ-017 All index arithmetic SHALL be 8-bit with natural wrap-around; k SHALL be 9-bit internally so len=255 terminates correctly.
REQ-018 len=0: the block SHALL write CT[0]=0, perform no PRGA iteration, and go to DONE.
REQ-019 When i=j, the swap SHALL write the same value twice to the same address without corruption.
REQ-020 s_wren and ct_wren SHALL each be high for exactly one cycle per write and low in IDLE and DONE.
REQ-021 DONE SHALL last exactly one cycle; rdy SHALL be high on the following cycle.
REQ-022 Outputs SHALL be registered; there are no combinational paths from inputs to outputs except none (rdy decodes registered state only).

Reset
REQ-023 While rst_n=0, the FSM SHALL be in IDLE with rdy=1, all addresses/data=0, and s_wren=ct_wren=0.
REQ-024 Reset asserted mid-run SHALL abort immediately; partially written CT/S contents are undefined; the next start SHALL behave as a fresh run.

Configuration
REQ-025 Macro ARC4_ENC_KSA_EN defined: after start, the block SHALL write S[i]=i for i=0..255 (INIT, 256 cycles), then run KSA for i=0..255: j=(j+S[i]+key[i mod 3]) mod 256, swap S[i]/S[j]; then reset j to 0 before the PRGA.
REQ-026 Macro ARC4_ENC_KSA_EN undefined: INIT and KSA SHALL be omitted, key SHALL be unused, and S SHALL be taken as already scheduled by an upstream block.

Verification
REQ-027 Macro off, S=identity, PT=[0x00] -> CT[0]=0x00, exactly one ct write, rdy back high within 5 cycles.
REQ-028 Macro off, S=identity, PT=[0x02,0xAA,0x55] -> CT=[0x02,0xA8,0x50]; final S[2]=0x03, S[3]=0x02.
REQ-029 Macro on, key=0x000000, PT=[0x03,0x11,0x22,0x33] -> CT matches a software RC4 model; re-encrypting CT restores PT.
REQ-030 en pulsed repeatedly during a run -> exactly one run, ct write count = len+1.
REQ-031 rst_n pulsed low mid-PRGA -> rdy=1, wren signals 0 immediately; subsequent run with same inputs yields correct CT.
REQ-032 Macro off, S=identity, len=0xFF -> 256 ct writes, run terminates, i wraps correctly through 0xFF->0x00 not reached before end.
